// File: rtl/jvm_byte_fetcher.sv
// Bytecode byte fetcher: serves one byte per start/ready handshake from a 32-bit
// bytecode RAM through a single tagged line buffer, with next-word prefetch.
module jvm_byte_fetcher #(
  parameter int SIZE          = 1024,
  parameter int ADDRESS_WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic                     ready,
  output logic [7:0]               next_byte,
  output logic                     end_of_code,
  output logic                     busy,
  input  logic                     pc_load,
  input  logic [ADDRESS_WIDTH-1:0] pc_value,
  output logic [ADDRESS_WIDTH-1:0] pc,
  input  logic [ADDRESS_WIDTH:0]   code_len,
  output logic                     mem_rd,
  output logic [ADDRESS_WIDTH-3:0] mem_addr,
  input  logic [31:0]              mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    SERVE,
    MISS_REQ,
    MISS_WAIT,
    PF_WAIT
  } state_t;

  state_t state, state_next;

  logic [31:0]              buf_data;
  logic [ADDRESS_WIDTH-3:0] buf_tag;
  logic                     buf_valid;

  logic [ADDRESS_WIDTH-1:0] eff_pc;
  logic [ADDRESS_WIDTH-1:0] pc_inc;
  logic                     req_hit;
  logic                     req_eoc;
  logic                     pf_cond;

  function automatic logic [7:0] byte_at(input logic [31:0] w, input logic [1:0] off);
    logic [7:0] b;
    case (off)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

  // A same-cycle pc_load redirects the request, so hit/end checks use the loaded address.
  assign eff_pc  = pc_load ? pc_value : pc;
  assign req_hit = buf_valid && (buf_tag == eff_pc[ADDRESS_WIDTH-1:2]);
  assign req_eoc = ({1'b0, eff_pc} >= code_len);
  assign pf_cond = !start && !pc_load && buf_valid && (pc[1:0] == 2'd0) &&
                   (buf_tag != pc[ADDRESS_WIDTH-1:2]) && ({1'b0, pc} < code_len);
  assign pc_inc  = (pc == ADDRESS_WIDTH'(SIZE - 1)) ? '0 : pc + 1'b1;
  assign mem_addr = pc[ADDRESS_WIDTH-1:2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start)        state_next = (req_hit || req_eoc) ? SERVE : MISS_REQ;
        else if (pf_cond) state_next = PF_WAIT;
      end
      SERVE:     state_next = IDLE;
      MISS_REQ:  state_next = MISS_WAIT;
      MISS_WAIT: state_next = SERVE;
      PF_WAIT:   state_next = start ? SERVE : IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state != IDLE);
    mem_rd = (state == MISS_REQ) || ((state == IDLE) && pf_cond);
  end

  // Byte/flag registers load on entry to SERVE so they read out with ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= '0;
      ready       <= 1'b0;
      next_byte   <= '0;
      end_of_code <= 1'b0;
      buf_data    <= '0;
      buf_tag     <= '0;
      buf_valid   <= 1'b0;
    end else begin
      ready <= (state_next == SERVE);
      case (state)
        IDLE: begin
          if (pc_load) pc <= pc_value;
          if (start) begin
            if (req_eoc) begin
              next_byte   <= '0;
              end_of_code <= 1'b1;
            end else if (req_hit) begin
              next_byte   <= byte_at(buf_data, eff_pc[1:0]);
              end_of_code <= 1'b0;
            end
          end
        end
        SERVE: begin
          if (!end_of_code) pc <= pc_inc;
        end
        MISS_WAIT: begin
          buf_data    <= mem_rdata;
          buf_tag     <= pc[ADDRESS_WIDTH-1:2];
          buf_valid   <= 1'b1;
          next_byte   <= byte_at(mem_rdata, pc[1:0]);
          end_of_code <= 1'b0;
        end
        PF_WAIT: begin
          buf_data  <= mem_rdata;
          buf_tag   <= pc[ADDRESS_WIDTH-1:2];
          buf_valid <= 1'b1;
          if (start) begin
            next_byte   <= byte_at(mem_rdata, pc[1:0]);
            end_of_code <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
